apb2_ws2812_driver: RTL and testbench



---
 rtl/ws2812_pkg.sv | 45 ++++
 rtl/ws2812_fifo.sv | 57 +++++
 rtl/apb2_ws2812_driver.sv | 203 ++++++++++++++++++++
 tb/tb_apb2_ws2812_driver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants, FSM state type and per-bit timing helper for the WS2812 APB driver.
// Optional feature macro: WS2812_IRQ_EN (see apb2_ws2812_driver).
package ws2812_pkg;

   localparam logic [4:0] OFF_CTRL   = 5'h00;
   localparam logic [4:0] OFF_STATUS = 5'h04;
   localparam logic [4:0] OFF_DATA   = 5'h08;
   localparam logic [4:0] OFF_TH     = 5'h0C;
   localparam logic [4:0] OFF_TFRM   = 5'h10;

   localparam int unsigned CTRL_EN    = 0;
   localparam int unsigned CTRL_FLUSH = 1;
   localparam int unsigned CTRL_IRQEN = 2;

   localparam int unsigned ST_BUSY    = 0;
   localparam int unsigned ST_FULL    = 1;
   localparam int unsigned ST_EMPTY   = 2;
   localparam int unsigned ST_OVF     = 16;
   localparam int unsigned ST_DONE    = 17;

   localparam int unsigned T0H_DEF  = 20;
   localparam int unsigned T1H_DEF  = 40;
   localparam int unsigned TBIT_DEF = 63;
   localparam int unsigned TRST_DEF = 2600;

   typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} ws_state_e;

   typedef struct packed {
      logic [15:0] high_m1;
      logic [15:0] low_m1;
   } bit_timing_t;

   // Counter reload values (length - 1) for one bit; zero lengths clamp to one cycle.
   function automatic bit_timing_t bit_timing(input logic b, input logic [15:0] t0h,
                                              input logic [15:0] t1h, input logic [15:0] tbit);
      logic [15:0] th;
      bit_timing_t r;
      th = b ? t1h : t0h;
      if (th == '0) th = 16'd1;
      r.high_m1 = th - 16'd1;
      r.low_m1  = (tbit > th) ? (tbit - th - 16'd1) : '0;
      return r;
   endfunction

endpackage

// File: rtl/ws2812_fifo.sv
// Synchronous first-word-fall-through FIFO for 24-bit GRB pixel words.
module ws2812_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 24,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign level_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];

   // A pop frees the slot a same-cycle push into a full FIFO needs; flush discards the push.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & ~flush_i & (~full_o | do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/apb2_ws2812_driver.sv
// APB2 slave: pixel FIFO, timing registers and WS2812 serializer FSM.
// Define WS2812_IRQ_EN to add the registered irq output and the CTRL.IRQ_EN bit.
module apb2_ws2812_driver import ws2812_pkg::*; #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned T0H_RST    = T0H_DEF,
   parameter int unsigned T1H_RST    = T1H_DEF,
   parameter int unsigned TBIT_RST   = TBIT_DEF,
   parameter int unsigned TRST_RST   = TRST_DEF
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              led_dout
`ifdef WS2812_IRQ_EN
   ,output logic             irq
`endif
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   ws_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d, low_q, low_d;
   logic [23:0] sh_q, sh_d;
   logic [4:0]  bitcnt_q, bitcnt_d;
   logic        led_q, en_q, ovf_q, done_q;
   logic [15:0] t0h_q, t1h_q, tbit_q, trst_q;
   logic        pop, done_set, ovf_set, irqen_rd;
   bit_timing_t word_bt, next_bt;

   logic          fifo_full, fifo_empty;
   logic [23:0]   fifo_rdata;
   logic [LW-1:0] fifo_level;

   logic [4:0] reg_off;
   logic       wr_en, wr_ctrl, wr_status, wr_data, wr_th, wr_tfrm, flush;
   logic       unused_bits;

   assign reg_off   = {paddr[4:2], 2'b00};
   assign wr_en     = psel & penable & pwrite;
   assign wr_ctrl   = wr_en && (reg_off == OFF_CTRL);
   assign wr_status = wr_en && (reg_off == OFF_STATUS);
   assign wr_data   = wr_en && (reg_off == OFF_DATA);
   assign wr_th     = wr_en && (reg_off == OFF_TH);
   assign wr_tfrm   = wr_en && (reg_off == OFF_TFRM);
   assign flush     = wr_ctrl & pwdata[CTRL_FLUSH];
   assign ovf_set   = wr_data & fifo_full & ~pop & ~flush;
   assign unused_bits = ^{paddr[ADDR_W-1:5], paddr[1:0], sh_q[23]};

   ws2812_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
      .clk_i   (pclk),
      .rst_ni  (presetn),
      .push_i  (wr_data),
      .wdata_i (pwdata[23:0]),
      .pop_i   (pop),
      .flush_i (flush),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Timing is captured when a bit's HIGH phase starts: either a freshly popped word or the next shifted bit.
   assign word_bt = bit_timing(fifo_rdata[23], t0h_q, t1h_q, tbit_q);
   assign next_bt = bit_timing(sh_q[22], t0h_q, t1h_q, tbit_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      low_d    = low_q;
      sh_d     = sh_q;
      bitcnt_d = bitcnt_q;
      pop      = 1'b0;
      done_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en_q && !fifo_empty) begin
               pop      = 1'b1;
               sh_d     = fifo_rdata;
               bitcnt_d = 5'd23;
               cnt_d    = word_bt.high_m1;
               low_d    = word_bt.low_m1;
               state_d  = HIGH;
            end
         end
         HIGH: begin
            if (cnt_q == '0) begin
               cnt_d   = low_q;
               state_d = LOW;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         LOW: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (bitcnt_q != '0) begin
               sh_d     = {sh_q[22:0], 1'b0};
               bitcnt_d = bitcnt_q - 5'd1;
               cnt_d    = next_bt.high_m1;
               low_d    = next_bt.low_m1;
               state_d  = HIGH;
            end else if (en_q && !fifo_empty) begin
               pop      = 1'b1;
               sh_d     = fifo_rdata;
               bitcnt_d = 5'd23;
               cnt_d    = word_bt.high_m1;
               low_d    = word_bt.low_m1;
               state_d  = HIGH;
            end else begin
               cnt_d   = (trst_q == '0) ? '0 : trst_q - 16'd1;
               state_d = LATCH;
            end
         end
         LATCH: begin
            if (cnt_q == '0) begin
               done_set = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         low_q    <= '0;
         sh_q     <= '0;
         bitcnt_q <= '0;
         led_q    <= 1'b0;
         en_q     <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         t0h_q    <= 16'(T0H_RST);
         t1h_q    <= 16'(T1H_RST);
         tbit_q   <= 16'(TBIT_RST);
         trst_q   <= 16'(TRST_RST);
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         low_q    <= low_d;
         sh_q     <= sh_d;
         bitcnt_q <= bitcnt_d;
         led_q    <= (state_q == HIGH);
         if (wr_ctrl) en_q <= pwdata[CTRL_EN];
         ovf_q  <= ovf_set  | (ovf_q  & ~(wr_status & pwdata[ST_OVF]));
         done_q <= done_set | (done_q & ~(wr_status & pwdata[ST_DONE]));
         if (wr_th) begin
            t0h_q <= pwdata[15:0];
            t1h_q <= pwdata[31:16];
         end
         if (wr_tfrm) begin
            tbit_q <= pwdata[15:0];
            trst_q <= pwdata[31:16];
         end
      end
   end

`ifdef WS2812_IRQ_EN
   logic irqen_q, irq_q;

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         irqen_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (wr_ctrl) irqen_q <= pwdata[CTRL_IRQEN];
         irq_q <= irqen_q & (done_q | ovf_q);
      end
   end

   assign irqen_rd = irqen_q;
   assign irq      = irq_q;
`else
   assign irqen_rd = 1'b0;
`endif

   assign led_dout = led_q;

   always_comb begin
      prdata = '0;
      if (psel) begin
         unique case (reg_off)
            OFF_CTRL:   prdata = {29'b0, irqen_rd, 1'b0, en_q};
            OFF_STATUS: prdata = {14'b0, done_q, ovf_q, 8'(fifo_level), 5'b0,
                                  fifo_empty, fifo_full, state_q != IDLE};
            OFF_TH:     prdata = {t1h_q, t0h_q};
            OFF_TFRM:   prdata = {trst_q, tbit_q};
            default:    prdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb2_ws2812_driver.sv
// Self-checking bench for apb2_ws2812_driver: register table plus serial-timing sequences.
module tb_apb2_ws2812_driver;

   logic        pclk = 1'b0;
   logic        presetn, psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        led_dout;
`ifdef WS2812_IRQ_EN
   logic        irq;
   localparam logic [31:0] CTRL7_RB = 32'h0000_0005;
`else
   localparam logic [31:0] CTRL7_RB = 32'h0000_0001;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int m_t0h, m_t1h, m_tbit, m_trst;
   logic [23:0] words [16];

   typedef struct packed {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
   } vec_t;
   localparam int NV = 24;
   vec_t vecs [NV];

   apb2_ws2812_driver #(.FIFO_DEPTH(16), .ADDR_W(8), .T0H_RST(20), .T1H_RST(40),
                        .TBIT_RST(63), .TRST_RST(2600)) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .led_dout (led_dout)
`ifdef WS2812_IRQ_EN
      ,.irq     (irq)
`endif
   );

   always #5 pclk = ~pclk;

   initial begin
      #5ms;
      $display("FAIL watchdog: sim time exceeded, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      #1;
      d = prdata;
      psel = 1'b0;
   endtask

   task automatic model_defaults();
      m_t0h = 20; m_t1h = 40; m_tbit = 63; m_trst = 2600;
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      repeat (3) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
      model_defaults();
   endtask

   function automatic int exp_high(input logic b);
      int h;
      h = b ? m_t1h : m_t0h;
      return (h == 0) ? 1 : h;
   endfunction

   function automatic int exp_low(input logic b);
      int h;
      h = exp_high(b);
      return (m_tbit > h) ? m_tbit - h : 1;
   endfunction

   task automatic wait_rise(input string name);
      int n = 0;
      while (led_dout !== 1'b1 && n < 200) begin
         @(negedge pclk);
         n++;
      end
      chk(name, {31'b0, led_dout}, 32'd1);
   endtask

   // Entered at the first negedge with led_dout high; ends once the latch period finishes.
   task automatic check_frame(input int nw, input int chg_bit, input logic [31:0] chg_val,
                              input int abort_bit);
      int nb, h, l, k, eh, el;
      logic b;
      logic [31:0] st;
      nb = nw * 24;
      for (int i = 0; i < nb; i++) begin
         b = words[i/24][23 - (i % 24)];
         if (i % 24 == 0) begin
            apb_read(8'h04, st);
            chk($sformatf("level at word %0d", i/24), {24'b0, st[15:8]}, 32'(nw - 1 - i/24));
         end
         if (i == abort_bit) begin
            repeat (3) @(negedge pclk);
            presetn = 1'b0;
            @(negedge pclk);
            chk("led after reset", {31'b0, led_dout}, 32'd0);
            apb_read(8'h04, st);
            chk("status after reset", st, 32'h0000_0004);
            apb_read(8'h0C, st);
            chk("th after reset", st, 32'h0028_0014);
            presetn = 1'b1;
            @(negedge pclk);
            model_defaults();
            return;
         end
         eh = exp_high(b);
         el = exp_low(b);
         h = 0;
         if (i == chg_bit) begin
            apb_write(8'h0C, chg_val);
            h = 2;
            m_t0h = int'(chg_val[15:0]);
            m_t1h = int'(chg_val[31:16]);
         end
         while (led_dout === 1'b1 && h < 5000) begin
            h++;
            @(negedge pclk);
         end
         chk($sformatf("high bit %0d", i), h, eh);
         if (h >= 5000) return;
         if (i < nb - 1) begin
            l = 0;
            while (led_dout === 1'b0 && l < 5000) begin
               l++;
               @(negedge pclk);
            end
            chk($sformatf("low bit %0d", i), l, el);
            if (l >= 5000) return;
         end else begin
            // led_dout trails the FSM by one cycle, so busy drops one cycle before the low time elapses.
            k = 0;
            apb_read(8'h04, st);
            while (st[0] && k < 5000) begin
               @(negedge pclk);
               k++;
               apb_read(8'h04, st);
            end
            chk("last low + latch", k, el + ((m_trst == 0) ? 1 : m_trst) - 1);
         end
      end
   endtask

   initial begin
      logic [31:0] st;
      int kd, ki;

      vecs[0]  = '{1'b0, 8'h00, 32'h0000_0000};
      vecs[1]  = '{1'b0, 8'h04, 32'h0000_0004};
      vecs[2]  = '{1'b0, 8'h0C, 32'h0028_0014};
      vecs[3]  = '{1'b0, 8'h10, 32'h0A28_003F};
      vecs[4]  = '{1'b0, 8'h08, 32'h0000_0000};
      vecs[5]  = '{1'b0, 8'h14, 32'h0000_0000};
      vecs[6]  = '{1'b0, 8'h1C, 32'h0000_0000};
      vecs[7]  = '{1'b1, 8'h0C, 32'h1234_5678};
      vecs[8]  = '{1'b0, 8'h0C, 32'h1234_5678};
      vecs[9]  = '{1'b1, 8'h0C, 32'h0028_0014};
      vecs[10] = '{1'b0, 8'h0C, 32'h0028_0014};
      vecs[11] = '{1'b1, 8'h10, 32'hFFFF_0001};
      vecs[12] = '{1'b0, 8'h10, 32'hFFFF_0001};
      vecs[13] = '{1'b1, 8'h10, 32'h0A28_003F};
      vecs[14] = '{1'b1, 8'h00, 32'h0000_0007};
      vecs[15] = '{1'b0, 8'h00, CTRL7_RB};
      vecs[16] = '{1'b1, 8'h00, 32'h0000_0000};
      vecs[17] = '{1'b0, 8'h00, 32'h0000_0000};
      vecs[18] = '{1'b1, 8'h08, 32'h00AB_CDEF};
      vecs[19] = '{1'b0, 8'h04, 32'h0000_0100};
      vecs[20] = '{1'b1, 8'h00, 32'h0000_0002};
      vecs[21] = '{1'b0, 8'h04, 32'h0000_0004};
      vecs[22] = '{1'b1, 8'h04, 32'hFFFF_FFFF};
      vecs[23] = '{1'b0, 8'h04, 32'h0000_0004};

      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      presetn = 1'b0;
      @(negedge pclk);
      do_reset();
      chk("led at reset", {31'b0, led_dout}, 32'd0);
      chk("prdata idle", prdata, 32'd0);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr) begin
            apb_write(vecs[i].addr, vecs[i].data);
         end else begin
            apb_read(vecs[i].addr, st);
            chk($sformatf("vec %0d addr 0x%02h", i, vecs[i].addr), st, vecs[i].data);
            @(negedge pclk);
         end
      end

      // One word 0x800001: first-pulse latency then full frame timing.
      apb_write(8'h00, 32'h1);
      words[0] = 24'h800001;
      apb_write(8'h08, {8'h0, words[0]});
      chk("led N+0", {31'b0, led_dout}, 32'd0);
      @(negedge pclk);
      chk("led N+1", {31'b0, led_dout}, 32'd0);
      @(negedge pclk);
      chk("led N+2", {31'b0, led_dout}, 32'd1);
      check_frame(1, -1, 32'h0, -1);
      apb_read(8'h04, st);
      chk("status after frame 1", st, 32'h0002_0004);

      // Two words queued with EN low, then released back to back.
      apb_write(8'h04, 32'h0003_0000);
      apb_write(8'h00, 32'h0);
      words[0] = 24'hFF00AA;
      words[1] = 24'h0F0F01;
      apb_write(8'h08, {8'h0, words[0]});
      apb_write(8'h08, {8'h0, words[1]});
      apb_read(8'h04, st);
      chk("status two queued", st, 32'h0000_0200);
      apb_write(8'h00, 32'h1);
      wait_rise("rise two words");
      check_frame(2, -1, 32'h0, -1);
      apb_read(8'h04, st);
      chk("status after frame 2", st, 32'h0002_0004);

      // Overflow: 16 accepted, 17th dropped and never sent.
      apb_write(8'h04, 32'h0003_0000);
      apb_write(8'h00, 32'h0);
      for (int i = 0; i < 16; i++) begin
         words[i] = {8'(i), 8'h5A, 8'(~i)};
         apb_write(8'h08, {8'h0, words[i]});
      end
      apb_read(8'h04, st);
      chk("status full", st, 32'h0000_1002);
      apb_write(8'h08, 32'h00FF_FFFF);
      apb_read(8'h04, st);
      chk("status ovf", st, 32'h0001_1002);
      apb_write(8'h04, 32'h0001_0000);
      apb_read(8'h04, st);
      chk("status ovf cleared", st, 32'h0000_1002);
      apb_write(8'h00, 32'h1);
      wait_rise("rise full fifo");
      check_frame(16, -1, 32'h0, -1);
      apb_read(8'h04, st);
      chk("status after frame 16", st, 32'h0002_0004);

      // Zero timing values clamp every phase to one cycle.
      apb_write(8'h04, 32'h0002_0000);
      apb_write(8'h0C, 32'h0);
      apb_write(8'h10, 32'h0);
      m_t0h = 0; m_t1h = 0; m_tbit = 0; m_trst = 0;
      words[0] = 24'h000001;
      apb_write(8'h08, {8'h0, words[0]});
      wait_rise("rise zero timing");
      check_frame(1, -1, 32'h0, -1);
      apb_read(8'h04, st);
      chk("status after zero timing", st, 32'h0002_0004);

      // TH change during bit 5, then reset in the middle of bit 8.
      do_reset();
      apb_write(8'h00, 32'h1);
      words[0] = 24'hA5A5A5;
      apb_write(8'h08, {8'h0, words[0]});
      wait_rise("rise th change");
      check_frame(1, 5, 32'h0030_0010, 8);
      apb_read(8'h00, st);
      chk("ctrl after reset", st, 32'h0);

`ifdef WS2812_IRQ_EN
      apb_write(8'h00, 32'h5);
      words[0] = 24'h00000F;
      apb_write(8'h08, {8'h0, words[0]});
      kd = -1;
      ki = -1;
      for (int c = 0; c < 6000 && ki < 0; c++) begin
         apb_read(8'h04, st);
         if (kd < 0 && st[17]) kd = c;
         if (ki < 0 && irq) ki = c;
         @(negedge pclk);
      end
      chk("irq one cycle after done", ki, kd + 1);
      apb_write(8'h04, 32'h0002_0000);
      chk("irq still high at w1c edge", {31'b0, irq}, 32'd1);
      @(negedge pclk);
      chk("irq low after w1c", {31'b0, irq}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
